sram_mem_controller: RTL and testbench
======================================

# sram_mem_controller

Multi-cycle controller between the MEM stage and the board's 16-bit asynchronous SRAM. It turns a single-cycle 32-bit load/store request (`MEM_R_EN`/`MEM_W_EN` from the control path) into two sequenced halfword SRAM accesses. While an access is in flight it holds `ready` low, and the pipeline freezes on that signal. It owns the only SRAM port in the design.

## Interface
Parameters:
- `PHASE_CYCLES`, default 3: cycles per halfword phase. Legal values are 2 or more.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  store request (MEM_W_EN).
- `rd_en`  in  1  load request (MEM_R_EN).
- `address`  in  32  byte address from the ALU result.
- `write_data`  in  32  store data (Val_Rm).
- `read_data`  out  32  load result, registered.
- `ready`  out  1  high means no access is in flight; low freezes the pipeline.
- `sram_addr`  out  18  SRAM halfword address.
- `sram_dq_out`  out  16  write data driven to the SRAM.
- `sram_dq_oe`  out  1  tristate enable for `sram_dq_out`.
- `sram_dq_in`  in  16  data read back from the SRAM.
- `sram_we_n`  out  1  SRAM write strobe, active-low.
- `sram_oe_n`  out  1  SRAM output enable, active-low.

## Operation
- FSM states are IDLE, LO, HI and DONE. A phase counter `cnt` runs from 0 to PHASE_CYCLES-1 inside LO and HI.
- IDLE:
  - If `wr_en` or `rd_en` is high, latch `op` (write wins if both are high), the word index and `write_data`, then go to LO with `cnt`=0.
  - Otherwise stay in IDLE.
- Word index = (address − BASE_ADDR)[18:2], computed modulo 2^32 and truncated to 17 bits. Addresses below the base wrap; there is no range check. `address[1:0]` is ignored.
- LO:
  - `sram_addr` = {index, 1'b0}.
  - Write: `sram_dq_out` = wdata[15:0].
  - On `cnt`=PHASE_CYCLES-1, go to HI with `cnt` reset to 0.
- HI:
  - `sram_addr` = {index, 1'b1}.
  - Write: `sram_dq_out` = wdata[31:16].
  - On `cnt`=PHASE_CYCLES-1, go to DONE.
- DONE: lasts one cycle, then returns to IDLE unconditionally.
- Write strobes, per phase:
  - `sram_dq_oe`=1 for the whole phase.
  - `sram_we_n`=0 for cnt 0..PHASE_CYCLES-2 and 1 in the last cycle, so address and data are stable across the WE rising edge.
- Read strobes, per phase: `sram_oe_n`=0 for the whole phase; `sram_dq_oe`=0.
- Read capture:
  - In the last cycle of LO, `sram_dq_in` is registered into `read_data[15:0]`.
  - In the last cycle of HI, it is registered into `read_data[31:16]`.
  - `read_data` holds until the next read completes; writes never change it.
- `ready` (combinational) = (state==DONE) | (state==IDLE & !wr_en & !rd_en).
- Request inputs are sampled only in IDLE. Changes to them during LO/HI/DONE are ignored and the latched access completes.
- SRAM pins in IDLE and DONE: `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0. `sram_addr` and `sram_dq_out` hold their last values.

## Timing
- SRAM pin outputs are registered (Moore), so each pin changes one cycle after the state or count edge that selects it.
- Access latency, with the request first seen in IDLE at cycle 0:
  - LO covers cycles 1..P and HI covers P+1..2P.
  - DONE is cycle 2P+1, when `ready` goes high.
  - `ready` is low for 2P+1 cycles. For P=3, `ready` is low in cycles 0–6 and high in cycle 7.
- Read data: `read_data` is valid from cycle 2P+1 (it updates on the edge ending HI). It is therefore valid in DONE, the cycle in which the frozen pipeline advances.
- Back-to-back: a request present in the cycle after DONE starts a new access immediately. No idle bubble is required beyond DONE itself.
- Reset values, with `rst` high at any point including mid-access, applied on the next edge:
  - state=IDLE, `cnt`=0
  - `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `sram_oe_n`=1
- An aborted write may leave the SRAM with partial data. This is acceptable and is not retried.
- `ready` after reset = !(wr_en|rd_en).

## Test plan
- Reset: hold `rst` for 2 cycles with no request → all SRAM pins at their reset values, `read_data`=0, `ready`=1.
- Write then read, P=3: store 0x12345678 at 1024, then load 1024 →
  - write phases drive `sram_addr` 0 with 0x5678 and `sram_addr` 1 with 0x1234;
  - `sram_we_n` is low in 2 of the 3 cycles of each phase;
  - on the read, `ready` is high exactly 7 cycles after the request and `read_data`=0x12345678.
- Address mapping: load at 1028 → `sram_addr` 2, then 3. Load at 1020 → `sram_addr` 0x3FFFE, then 0x3FFFF (wrap).
- Simultaneous requests: `wr_en`=`rd_en`=1 → a write is performed and `sram_oe_n` stays 1 throughout.
- Request dropped: deassert `rd_en` in cycle 2 → the access still completes, DONE occurs in cycle 7, and `read_data` updates.
- Reset mid-access: assert `rst` in cycle 4 of a write → next cycle shows IDLE, `sram_we_n`=1, `sram_dq_oe`=0; a following read completes normally in 7 cycles.

Source files
------------

// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   Sequences one 32-bit load/store from the MEM stage into two halfword
//   accesses on the 16-bit asynchronous SRAM (low half first). `ready` stays
//   low while an access is in flight so the pipeline freezes.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   wr_en, rd_en        store / load request (write wins if both are high)
//   address             byte address; SRAM word 0 sits at BASE_ADDR
//   write_data          store data
//   read_data           registered load result, held until the next load
//   ready               high when no access is in flight
//   sram_addr           halfword address {word index, half select}
//   sram_dq_out/_oe     write data and its tristate enable
//   sram_dq_in          data returned by the SRAM
//   sram_we_n/oe_n      active-low write strobe / output enable
module sram_mem_controller #(
  parameter int          PHASE_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int CW = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_wr_q;
  logic [16:0]   idx_q;
  logic [31:0]   wdata_q;

  logic [17:0]   addr_d;
  logic [15:0]   dq_out_d;
  logic          dq_oe_d, we_n_d, oe_n_d;

  logic          req;
  logic          last;
  logic [31:0]   offset;
  logic          unused_ok;

  assign req    = wr_en | rd_en;
  assign last   = (cnt_q == CNT_LAST);
  // Subtraction wraps modulo 2^32, so addresses below the base alias onto
  // the top of the SRAM; the byte offset within a word is dropped.
  assign offset = address - BASE_ADDR;
  assign unused_ok = ^{offset[31:19], offset[1:0]};

  // State register, request latch, read capture and registered SRAM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register here is a control/datapath flop (no memory
      // arrays), so all of them take a defined reset value.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) begin
        op_wr_q <= wr_en;
        idx_q   <= offset[18:2];
        wdata_q <= write_data;
      end
      // The pins have shown this phase's address with oe_n low for at least
      // one cycle by the last count, so the SRAM output has settled.
      if (!op_wr_q && last) begin
        if (state_q == S_LO) read_data[15:0]  <= sram_dq_in;
        if (state_q == S_HI) read_data[31:16] <= sram_dq_in;
      end
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= dq_oe_d;
      sram_we_n   <= we_n_d;
      sram_oe_n   <= oe_n_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (req) begin
        state_d = S_LO;
        cnt_d   = '0;
      end
      S_LO: if (last) begin
        state_d = S_HI;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      S_HI: if (last) begin
        state_d = S_DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: ready, plus the values the SRAM pins take on the next edge.
  always_comb begin
    ready    = (state_q == S_DONE) || (state_q == S_IDLE && !req);
    addr_d   = sram_addr;
    dq_out_d = sram_dq_out;
    dq_oe_d  = 1'b0;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    if (state_q == S_LO || state_q == S_HI) begin
      addr_d = {idx_q, state_q == S_HI};
      if (op_wr_q) begin
        dq_out_d = (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
        dq_oe_d  = 1'b1;
        // WE rises in the last cycle so address and data straddle the edge.
        we_n_d   = last;
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: a behavioural SRAM, a per-cycle reference
// model of the access timeline, directed literal checks and random traffic.
module tb_sram_mem_controller;

  localparam int          P    = 3;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_mem_controller #(.PHASE_CYCLES(P), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural SRAM ----------------
  function automatic logic [15:0] sram_default(input logic [17:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[17:16], 14'h0};
  endfunction

  logic [15:0] sram_mem [0:262143];
  initial for (int i = 0; i < 262144; i++) sram_mem[i] = sram_default(18'(i));

  assign sram_dq_in = !sram_oe_n ? sram_mem[sram_addr] : 16'h0BAD;

  always @(posedge sram_we_n)
    if (sram_dq_oe === 1'b1) sram_mem[sram_addr] <= sram_dq_out;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_word(input logic [16:0] idx);
    if (ref_mem.exists(int'(idx))) return ref_mem[int'(idx)];
    return {sram_default({idx, 1'b1}), sram_default({idx, 1'b0})};
  endfunction

  function automatic logic [16:0] word_index(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return d[18:2];
  endfunction

  bit          m_valid = 0;
  int          k = -1, prev_k = -1, cur_k;
  bit          m_op;
  logic [16:0] m_idx;
  logic [31:0] m_wdata, m_rdata;
  logic [17:0] m_addr;
  logic [15:0] m_dq;

  // k counts cycles since the request was accepted (k=0 in IDLE, LO = 1..P,
  // HI = P+1..2P, DONE = 2P+1). Pins are registered, so they reflect the
  // previous cycle's position in that timeline.
  always @(negedge clk) begin
    bit e_we, e_oe, e_dqoe, hi;
    int c;
    #2;
    if (m_valid) begin
      cur_k = (k >= 0) ? k : ((wr_en || rd_en) ? 0 : -1);
      e_we = 1'b1; e_oe = 1'b1; e_dqoe = 1'b0;
      if (prev_k >= 1 && prev_k <= 2*P) begin
        hi = (prev_k > P);
        c  = (prev_k - 1) % P;
        m_addr = {m_idx, hi};
        if (m_op) begin
          e_dqoe = 1'b1;
          e_we   = (c == P-1);
          m_dq   = hi ? m_wdata[31:16] : m_wdata[15:0];
        end else begin
          e_oe = 1'b0;
        end
      end
      check("ready", 32'(ready), 32'((cur_k < 0) || (cur_k == 2*P+1)));
      check("read_data", read_data, m_rdata);
      check("sram_addr", 32'(sram_addr), 32'(m_addr));
      check("sram_dq_out", 32'(sram_dq_out), 32'(m_dq));
      check("sram_dq_oe", 32'(sram_dq_oe), 32'(e_dqoe));
      check("sram_we_n", 32'(sram_we_n), 32'(e_we));
      check("sram_oe_n", 32'(sram_oe_n), 32'(e_oe));
      if (cur_k == 0) begin
        m_op    = wr_en;
        m_idx   = word_index(address);
        m_wdata = write_data;
        if (wr_en) ref_mem[int'(m_idx)] = write_data;
      end
      if (!m_op && cur_k == P)   m_rdata[15:0]  = ref_word(m_idx)[15:0];
      if (!m_op && cur_k == 2*P) m_rdata[31:16] = ref_word(m_idx)[31:16];
    end
    if (rst) begin
      m_valid = 1; k = -1; prev_k = -1;
      m_addr = '0; m_dq = '0; m_rdata = '0;
    end else if (m_valid) begin
      prev_k = cur_k;
      k = (cur_k >= 0 && cur_k < 2*P+1) ? cur_k + 1 : -1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic rs);
    @(negedge clk);
    rst = rs; wr_en = w; rd_en = r; address = a; write_data = d;
    #3;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Load `a`; check ready timing and the literal result in DONE (cycle 7).
  task automatic read_literal(input logic [31:0] a, input logic [31:0] exp, input string tag);
    tick(1'b0, 1'b1, a, 32'h0, 1'b0);
    check({tag, "_ready_c0"}, 32'(ready), 32'd0);
    for (int c = 1; c <= 7; c++) begin
      idle();
      if (c == 6) check({tag, "_ready_c6"}, 32'(ready), 32'd0);
      if (c == 7) begin
        check({tag, "_ready_c7"}, 32'(ready), 32'd1);
        check({tag, "_data"}, read_data, exp);
      end
    end
  endtask

  initial begin
    int we_lo, we_hi, oe_low;

    // Reset: two cycles, no request.
    tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_ready", 32'(ready), 32'd1);

    // Store 0x12345678 at 1024.
    tick(1'b1, 1'b0, 32'd1024, 32'h12345678, 1'b0);
    we_lo = 0; we_hi = 0;
    for (int c = 1; c <= 8; c++) begin
      idle();
      if (c >= 2 && c <= 4) begin
        check("wr_lo_addr", 32'(sram_addr), 32'd0);
        check("wr_lo_data", 32'(sram_dq_out), 32'h5678);
        if (!sram_we_n) we_lo++;
      end
      if (c >= 5 && c <= 7) begin
        check("wr_hi_addr", 32'(sram_addr), 32'd1);
        check("wr_hi_data", 32'(sram_dq_out), 32'h1234);
        if (!sram_we_n) we_hi++;
      end
    end
    check("wr_we_lo_cycles", 32'(we_lo), 32'd2);
    check("wr_we_hi_cycles", 32'(we_hi), 32'd2);

    read_literal(32'd1024, 32'h12345678, "rd1024");

    // Address mapping, including wrap below the base.
    tick(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      idle();
      if (c == 3) check("map1028_lo", 32'(sram_addr), 32'd2);
      if (c == 6) check("map1028_hi", 32'(sram_addr), 32'd3);
    end
    tick(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      idle();
      if (c == 3) check("map1020_lo", 32'(sram_addr), 32'h3FFFE);
      if (c == 6) check("map1020_hi", 32'(sram_addr), 32'h3FFFF);
    end

    // Simultaneous request: write wins, OE never asserted.
    tick(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
    oe_low = 0; we_lo = 0;
    for (int c = 1; c <= 8; c++) begin
      idle();
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) we_lo++;
    end
    check("both_oe_low_cycles", 32'(oe_low), 32'd0);
    check("both_we_low_cycles", 32'(we_lo), 32'd4);
    read_literal(32'd1032, 32'hCAFEF00D, "rd1032");

    // Request dropped in cycle 2: access still completes in cycle 7.
    tick(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    for (int c = 2; c <= 7; c++) begin
      idle();
      if (c == 6) check("drop_ready_c6", 32'(ready), 32'd0);
      if (c == 7) begin
        check("drop_ready_c7", 32'(ready), 32'd1);
        check("drop_data", read_data, 32'h12345678);
      end
    end

    // Reset in cycle 4 of a write.
    tick(1'b1, 1'b0, 32'd1036, 32'hA5A55A5A, 1'b0);
    idle(); idle(); idle();
    tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_read_data", read_data, 32'd0);
    read_literal(32'd1024, 32'h12345678, "post_abort");
    // Restore the partially written word so later reads have a defined value.
    tick(1'b1, 1'b0, 32'd1036, 32'h0F0F1E1E, 1'b0);
    for (int c = 1; c <= 8; c++) idle();

    // Random traffic, including back-to-back and held requests.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0)
        a = BASE - 32'(4 * $urandom_range(1, 3)) + 32'($urandom_range(0, 3));
      else
        a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      tick(sel == 1 || sel == 3, sel == 2 || sel == 3 || sel == 4, a, $urandom, 1'b0);
    end
    for (int c = 0; c < 10; c++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
